// File: rtl/slow_intr_gateway.sv
// Edge-triggered interrupt gateway: each source walks IDLE -> PENDING -> IN_SERVICE
// under a claim/complete handshake, with one deferred edge and a sticky lost-edge flag.
module slow_intr_gateway #(
  parameter int INTR_WIDTH = 1,
  parameter int ID_WIDTH   = 5
) (
  input  logic                  slow_clk,
  input  logic                  slow_resetn,
  input  logic [INTR_WIDTH-1:0] slow_intr,
  input  logic [INTR_WIDTH-1:0] intr_mask,
  output logic                  irq,
  output logic                  claim_valid,
  output logic [ID_WIDTH-1:0]   claim_id,
  input  logic                  claim_ready,
  input  logic                  complete_valid,
  input  logic [ID_WIDTH-1:0]   complete_id,
  output logic [INTR_WIDTH-1:0] pending,
  output logic [INTR_WIDTH-1:0] in_service,
  output logic [INTR_WIDTH-1:0] overflow,
  input  logic [INTR_WIDTH-1:0] ovf_clr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;

  logic [INTR_WIDTH-1:0] req;

  assign req         = pending & intr_mask;
  assign claim_valid = |req;
  assign irq         = claim_valid;

  // NOTE: blocking assignments in always_comb; iterating downward lets the lowest index win.
  always_comb begin
    claim_id = '0;
    for (int i = INTR_WIDTH - 1; i >= 0; i--) begin
      if (req[i]) claim_id = ID_WIDTH'(i + 1);
    end
  end

  for (genvar i = 0; i < INTR_WIDTH; i++) begin : g_src
    logic [1:0] st_q, st_d;
    logic       def_q, def_d;
    logic       ovf_q, ovf_d, ovf_set;
    logic       prev_q;
    logic       rise;
    logic       claim_hit;
    logic       complete_hit;

    assign rise         = slow_intr[i] & ~prev_q;
    assign claim_hit    = claim_valid & claim_ready & (claim_id == ID_WIDTH'(i + 1));
    assign complete_hit = complete_valid & (complete_id == ID_WIDTH'(i + 1)) & (st_q == ST_SERV);

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
      st_d    = st_q;
      def_d   = def_q;
      ovf_set = 1'b0;
      case (st_q)
        ST_IDLE: if (rise) st_d = ST_PEND;
        ST_PEND: begin
          if (claim_hit) begin
            st_d  = ST_SERV;
            def_d = rise;
          end else if (rise) begin
            ovf_set = 1'b1;
          end
        end
        ST_SERV: begin
          if (complete_hit) begin
            def_d = 1'b0;
            if (def_q) begin
              st_d    = ST_PEND;
              ovf_set = rise;
            end else begin
              st_d = rise ? ST_PEND : ST_IDLE;
            end
          end else if (rise) begin
            if (def_q) ovf_set = 1'b1;
            else       def_d   = 1'b1;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          def_d = 1'b0;
        end
      endcase
      ovf_d = ovf_set | (ovf_q & ~ovf_clr[i]);
    end

    // NOTE: prev resets to 1 so a line already high at reset release is not taken as an edge.
    always_ff @(posedge slow_clk or negedge slow_resetn) begin
      if (!slow_resetn) begin
        st_q   <= ST_IDLE;
        def_q  <= 1'b0;
        ovf_q  <= 1'b0;
        prev_q <= 1'b1;
      end else begin
        st_q   <= st_d;
        def_q  <= def_d;
        ovf_q  <= ovf_d;
        prev_q <= slow_intr[i];
      end
    end

    assign pending[i]    = (st_q == ST_PEND);
    assign in_service[i] = (st_q == ST_SERV);
    assign overflow[i]   = ovf_q;
  end

endmodule

// File: doc/slow_intr_gateway.md
SLOW_INTR_GATEWAY -- requirements
Module: slow_intr_gateway

Interface
REQ-001 SHALL have parameter INTR_WIDTH, default 1, number of interrupt sources (1..31).
REQ-002 SHALL have parameter ID_WIDTH, default 5, width of claim/complete IDs; source i has ID i+1, ID 0 = none.
REQ-003 SHALL have port slow_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port slow_resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port slow_intr  input  INTR_WIDTH  rising-edge-sensitive interrupts, already synchronized into slow_clk.
REQ-006 SHALL have port intr_mask  input  INTR_WIDTH  per-source enable, 1 = enabled.
REQ-007 SHALL have port irq  output  1  level interrupt to the interrupt manager.
REQ-008 SHALL have port claim_valid  output  1  an enabled pending source is available.
REQ-009 SHALL have port claim_id  output  ID_WIDTH  ID offered for claim.
REQ-010 SHALL have port claim_ready  input  1  manager accepts claim_id this cycle.
REQ-011 SHALL have port complete_valid  input  1  manager finished servicing complete_id.
REQ-012 SHALL have port complete_id  input  ID_WIDTH  ID being completed.
REQ-013 SHALL have port pending  output  INTR_WIDTH  per-source PENDING state.
REQ-014 SHALL have port in_service  output  INTR_WIDTH  per-source IN_SERVICE state.
REQ-015 SHALL have port overflow  output  INTR_WIDTH  sticky lost-edge flags.
REQ-016 SHALL have port ovf_clr  input  INTR_WIDTH  write-1-to-clear for overflow.

Function
REQ-017 SHALL detect edge[i] = slow_intr[i] & ~prev[i], prev[i] registered from slow_intr[i] every cycle.
REQ-018 SHALL keep per source a state machine IDLE / PENDING / IN_SERVICE plus a deferred bit valid only in IN_SERVICE.
REQ-019 SHALL transition IDLE->PENDING on edge; state visible one cycle after the edge cycle.
REQ-020 SHALL transition PENDING->IN_SERVICE on claim_valid & claim_ready with claim_id = that source's ID.
REQ-021 SHALL transition IN_SERVICE->IDLE on complete_valid with matching ID when deferred = 0, and IN_SERVICE->PENDING when deferred = 1 (deferred cleared).
REQ-022 SHALL set deferred on edge in IN_SERVICE when deferred = 0.
REQ-023 SHALL set overflow[i] on edge while PENDING, or while IN_SERVICE with deferred = 1; the edge is otherwise discarded.
REQ-024 SHALL treat edge in same cycle as claim of that source as arriving in IN_SERVICE: sets deferred, no overflow.
REQ-025 SHALL treat edge in same cycle as matching complete as arriving after complete: next state PENDING; overflow only if deferred was already 1 (next state PENDING, deferred 0).
REQ-026 SHALL ignore complete_valid with ID 0, ID > INTR_WIDTH, or ID of a source not IN_SERVICE: no state change.
REQ-027 SHALL give overflow set priority over ovf_clr in the same cycle.
REQ-028 SHALL drive irq = claim_valid = |(pending & intr_mask), combinational from registered state.
REQ-029 SHALL drive claim_id = ID of lowest-index source with pending & intr_mask, 0 when none.
REQ-030 SHALL still latch edges of masked sources into PENDING; they raise irq when unmasked.
REQ-031 SHALL let claim_valid/claim_id change without handshake (mask change, etc.); only the values at the claim_ready cycle are binding.
REQ-032 SHALL accept at most one claim and one complete per cycle; both may target different sources in the same cycle.

Reset
REQ-033 SHALL, on slow_resetn low, asynchronously force all sources IDLE, deferred 0, overflow 0, prev all-ones.
REQ-034 SHALL drive irq 0, claim_valid 0, claim_id 0, pending 0, in_service 0, overflow 0 during reset.
REQ-035 SHALL NOT register an edge for a slow_intr bit held high through reset release (prev all-ones).
REQ-036 SHALL discard in-progress claims/services on mid-operation reset; no edge replay after release.

Verification
REQ-037 SHALL cover: INTR_WIDTH=4, mask=4'hF, slow_intr[2] 0->1 at cycle N -> pending=4'b0100, irq=1, claim_id=3 at N+1.
REQ-038 SHALL cover: edges on sources 1 and 3 same cycle -> claim_id=2; after claim, claim_id=4 next cycle, in_service=4'b0010.
REQ-039 SHALL cover: source 0 IN_SERVICE, two edges -> deferred then overflow[0]=1; complete_id=1 -> pending[0]=1, in_service[0]=0.
REQ-040 SHALL cover: mask=4'h0, edge on source 0 -> pending[0]=1, irq=0; mask=4'h1 -> irq=1 same cycle.
REQ-041 SHALL cover: complete_id=0, 7, and ID of PENDING source -> no state change in any output.
REQ-042 SHALL cover: slow_intr=4'hF held through reset release -> pending stays 0; reset asserted with source IN_SERVICE -> all outputs 0 immediately.
